// File: rtl/feistel_engine.sv
// Parametrised Blowfish-style Feistel engine: encrypts or decrypts one
// 64-bit block (L,R) against external P-array and four S-box SRAMs.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, decrypt      block request (accepted while ready=1), mode bit
//   L, R                input block halves, sampled with an accepted start
//   ready, done         accept window (IDLE/DONE), one-cycle result strobe
//   sN_addr/sN_cs_l     S-box read requests, sN_out read data (RL later)
//   p_addr/p_cs_l       P-array read request, p_out read data (RL later)
//   resultL, resultR    output block, held until the next block finishes
module feistel_engine #(
  parameter int ROUNDS   = 16,
  parameter int READ_LAT = 2,
  parameter int P_AW     = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            decrypt,
  input  logic [31:0]     L,
  input  logic [31:0]     R,
  output logic            ready,
  input  logic [31:0]     s1_out,
  input  logic [31:0]     s2_out,
  input  logic [31:0]     s3_out,
  input  logic [31:0]     s4_out,
  output logic [7:0]      s1_addr,
  output logic [7:0]      s2_addr,
  output logic [7:0]      s3_addr,
  output logic [7:0]      s4_addr,
  output logic            s1_cs_l,
  output logic            s2_cs_l,
  output logic            s3_cs_l,
  output logic            s4_cs_l,
  input  logic [31:0]     p_out,
  output logic [P_AW-1:0] p_addr,
  output logic            p_cs_l,
  output logic [31:0]     resultL,
  output logic [31:0]     resultR,
  output logic            done
);

  // Counter holds 0..N+1 so the final-round test never aliases.
  localparam int RW = $clog2(ROUNDS + 2);

  localparam logic [RW-1:0]   N_R   = RW'(ROUNDS);
  localparam logic [RW-1:0]   FIN_K = RW'(ROUNDS + 1);
  localparam logic [P_AW-1:0] LAST  = P_AW'(ROUNDS + 1);

  // Wait-state terminal counts: full latency for P-only waits,
  // latency-1 after a round request (the update cycle is the last).
  localparam logic [2:0] W_FULL = 3'(READ_LAT - 1);
  localparam logic [2:0] W_RND  =
    3'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P0_WAIT,
    S_RND_REQ,
    S_RND_WAIT,
    S_RND_UPD,
    S_FIN_REQ,
    S_FIN_WAIT,
    S_DONE
  } state_t;

  state_t state;
  state_t nstate;

  logic [31:0]   r_l;
  logic [31:0]   r_r;
  logic          mode;
  logic [RW-1:0] round;
  logic [2:0]    wcnt;

  logic          full_last;
  logic          rnd_last;
  logic          accept;
  logic          waiting;
  logic [31:0]   f_val;

  // Decrypt walks the P-array from the top end.
  function automatic logic [P_AW-1:0] idx(
    input logic          dec,
    input logic [RW-1:0] k
  );
    logic [P_AW-1:0] kw;
    kw = P_AW'(k);
    return dec ? (LAST - kw) : kw;
  endfunction

  assign full_last = (wcnt == W_FULL);
  assign rnd_last  = (wcnt == W_RND);

  assign waiting = (state == S_P0_WAIT)
                || (state == S_RND_WAIT)
                || (state == S_FIN_WAIT);

  assign accept = start
               && ((state == S_IDLE) || (state == S_DONE));

  assign f_val = ((s1_out + s2_out) ^ s3_out) + s4_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate  = state;
    ready   = 1'b0;
    done    = 1'b0;
    p_cs_l  = 1'b1;
    p_addr  = '0;
    s1_cs_l = 1'b1;
    s2_cs_l = 1'b1;
    s3_cs_l = 1'b1;
    s4_cs_l = 1'b1;
    s1_addr = 8'd0;
    s2_addr = 8'd0;
    s3_addr = 8'd0;
    s4_addr = 8'd0;
    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          p_cs_l = 1'b0;
          p_addr = idx(decrypt, '0);
          nstate = S_P0_WAIT;
        end
      end
      S_P0_WAIT: begin
        if (full_last) begin
          nstate = S_RND_REQ;
        end
      end
      S_RND_REQ: begin
        s1_cs_l = 1'b0;
        s2_cs_l = 1'b0;
        s3_cs_l = 1'b0;
        s4_cs_l = 1'b0;
        s1_addr = r_l[31:24];
        s2_addr = r_l[23:16];
        s3_addr = r_l[15:8];
        s4_addr = r_l[7:0];
        p_cs_l  = 1'b0;
        p_addr  = idx(mode, round);
        nstate  = (READ_LAT == 1) ? S_RND_UPD : S_RND_WAIT;
      end
      S_RND_WAIT: begin
        if (rnd_last) begin
          nstate = S_RND_UPD;
        end
      end
      S_RND_UPD: begin
        nstate = (round == N_R) ? S_FIN_REQ : S_RND_REQ;
      end
      S_FIN_REQ: begin
        p_cs_l = 1'b0;
        p_addr = idx(mode, FIN_K);
        nstate = S_FIN_WAIT;
      end
      S_FIN_WAIT: begin
        if (full_last) begin
          nstate = S_DONE;
        end
      end
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          p_cs_l = 1'b0;
          p_addr = idx(decrypt, '0);
          nstate = S_P0_WAIT;
        end else begin
          nstate = S_IDLE;
        end
      end
      default: begin
        nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_l     <= 32'd0;
      r_r     <= 32'd0;
      mode    <= 1'b0;
      round   <= '0;
      wcnt    <= 3'd0;
      resultL <= 32'd0;
      resultR <= 32'd0;
    end else begin
      if (waiting && (nstate == state)) begin
        wcnt <= wcnt + 3'd1;
      end else begin
        wcnt <= 3'd0;
      end

      if (accept) begin
        r_l   <= L;
        r_r   <= R;
        mode  <= decrypt;
        round <= '0;
      end

      if ((state == S_P0_WAIT) && full_last) begin
        r_l   <= r_l ^ p_out;
        round <= RW'(1);
      end

      if (state == S_RND_UPD) begin
        r_l   <= r_r ^ f_val ^ p_out;
        r_r   <= r_l;
        round <= round + RW'(1);
      end

      if ((state == S_FIN_WAIT) && full_last) begin
        resultL <= r_r ^ p_out;
        resultR <= r_l;
      end
    end
  end

endmodule
